// File: rtl/cpu_bus_pkg.sv
// Shared CPU data-bus definitions.
// Used by the tri-state bus drivers and the bus capture reader.
package cpu_bus_pkg;

  localparam int BUS_WIDTH = 8;

  typedef logic [BUS_WIDTH-1:0] bus_word_t;

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH storage with synchronous write and asynchronous indexed read.
// Entries are not reset; their contents are don't-care until written.
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bus_capture_fifo.sv
// Reader end of the shared tri-state CPU data bus.
// Captures driven words into a FIFO, counts overflow drops, flags a floating bus.
module bus_capture_fifo
  import cpu_bus_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH,
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] busData,
  input  logic             busEnable,
  output logic [WIDTH-1:0] outData,
  output logic             outValid,
  input  logic             outReady,
  output logic             full,
  output logic [CNTW-1:0]  dropCount,
  output logic             floatErr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [CNTW-1:0] DROP_ONE = CNTW'(1);

  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic [CNTW-1:0]  r_drop;
  logic             r_float;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic             w_full;
  logic             w_valid;
  logic [WIDTH-1:0] w_rdata;

  assign w_full  = (r_count == FULL_CNT);
  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid && outReady;
  // A pop frees a slot in the same edge, so a full FIFO still accepts.
  assign w_push  = busEnable && (!w_full || w_pop);
  assign w_drop  = busEnable && w_full && !w_pop;

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata (busData),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop <= '0;
    end else if (w_drop && (r_drop != '1)) begin
      r_drop <= r_drop + DROP_ONE;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_float <= 1'b0;
    end else if (busEnable && $isunknown(^busData)) begin
      r_float <= 1'b1;
    end
  end
`else
  assign r_float = 1'b0;
`endif

  assign outData   = w_valid ? w_rdata : '0;
  assign outValid  = w_valid;
  assign full      = w_full;
  assign dropCount = r_drop;
  assign floatErr  = r_float;

endmodule
